ext_mem_stream_feeder: RTL and testbench

Host-side transmitter for the chip's `a`/`b` operand streams. It reads a contiguous range of external-memory words and unpacks each word into `IO_DATA_WIDTH` lanes. The lanes go out on a valid/ready stream that connects directly to `a_input`/`a_valid`/`a_ready` or `b_input`/`b_valid`/`b_ready` of the system. One instance drives each operand stream, and each instance has its own read port on a memory with 1-cycle read latency.

---
 rtl/stream_feeder_pkg.sv | 20 ++
 rtl/feeder_word_fifo.sv | 63 ++++++
 rtl/ext_mem_stream_feeder.sv | 135 +++++++++++++
 tb/tb_ext_mem_stream_feeder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_feeder_pkg.sv
// Shared types and helpers for the external-memory operand stream feeder.
package stream_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int calc_lanes(input int ext_w, input int io_w);
    return (io_w > 0) ? ext_w / io_w : 0;
  endfunction

  function automatic bit width_ok(input int ext_w, input int io_w);
    return (io_w > 0) && ((ext_w % io_w) == 0);
  endfunction

endpackage

// File: rtl/feeder_word_fifo.sv
// Two-entry word buffer between the memory read port and the lane mux.
module feeder_word_fifo
  import stream_feeder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == 2'(FIFO_DEPTH));
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = head_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push && do_pop) begin
      if (count_q == 2'd1) begin
        head_d = push_data;
      end else begin
        head_d = tail_q;
        tail_d = push_data;
      end
    end else if (do_push) begin
      if (count_q == 2'd0) head_d = push_data;
      else                 tail_d = push_data;
      count_d = count_q + 2'd1;
    end else if (do_pop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ext_mem_stream_feeder.sv
// Streams a contiguous range of external-memory words out as IO_DATA_WIDTH lanes,
// lane 0 first, over a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; latches base address and word count
// RUN   | issuing reads and emitting lanes until the last lane handshakes
// DONE  | one-cycle done pulse, then back to IDLE
module ext_mem_stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int IO_DATA_WIDTH  = 16,
  parameter int EXT_MEM_WIDTH  = 32,
  parameter int EXT_MEM_HEIGHT = 1 << 20
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              start,
  input  logic [$clog2(EXT_MEM_HEIGHT)-1:0] base_addr,
  input  logic [$clog2(EXT_MEM_HEIGHT):0]   word_count,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(EXT_MEM_HEIGHT)-1:0] mem_read_addr,
  output logic                              mem_read_en,
  input  logic [EXT_MEM_WIDTH-1:0]          mem_qout,
  output logic [IO_DATA_WIDTH-1:0]          out_data,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int AW    = $clog2(EXT_MEM_HEIGHT);
  localparam int CW    = AW + 1;
  localparam int LANES = calc_lanes(EXT_MEM_WIDTH, IO_DATA_WIDTH);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  if (!width_ok(EXT_MEM_WIDTH, IO_DATA_WIDTH)) begin : g_width_check
    $error("EXT_MEM_WIDTH must be an integer multiple of IO_DATA_WIDTH");
  end

  feeder_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] issue_left_q, issue_left_d;
  logic [CW-1:0] emit_left_q, emit_left_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          inflight_q, inflight_d;

  logic                      fifo_full, fifo_empty;
  logic [1:0]                fifo_count;
  logic [EXT_MEM_WIDTH-1:0]  fifo_head;
  logic [LANES-1:0][IO_DATA_WIDTH-1:0] head_lanes;
  logic                      xfer, last_lane, pop, push, rd_en;
  logic [2:0]                pending;

  feeder_word_fifo #(.WIDTH(EXT_MEM_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (push),
    .push_data (mem_qout),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign head_lanes = fifo_head;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : head_lanes[lane_q];
  assign xfer       = out_valid && out_ready;
  assign last_lane  = (lane_q == LW'(LANES - 1));
  assign pop        = xfer && last_lane;
  // In-flight data lands the cycle after its read; the in-flight flag is
  // cleared by reset so a read straddling reset is dropped here.
  assign push       = inflight_q && (!fifo_full || pop);
  assign pending    = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign mem_read_en   = rd_en;
  assign mem_read_addr = addr_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    emit_left_d  = emit_left_q;
    lane_d       = lane_q;
    rd_en        = 1'b0;

    if (xfer) lane_d = last_lane ? '0 : lane_q + 1'b1;
    if (pop)  emit_left_d = emit_left_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          issue_left_d = word_count;
          emit_left_d  = word_count;
          lane_d       = '0;
          state_d      = (word_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = (issue_left_q != '0) && (pending < 3'd2);
        if (rd_en) begin
          issue_left_d = issue_left_q - 1'b1;
          addr_d = (addr_q == AW'(EXT_MEM_HEIGHT - 1)) ? '0 : addr_q + 1'b1;
        end
        if (pop && (emit_left_q == CW'(1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign inflight_d = rd_en;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      emit_left_q  <= '0;
      lane_q       <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      emit_left_q  <= emit_left_d;
      lane_q       <= lane_d;
      inflight_q   <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ext_mem_stream_feeder.sv
// Self-checking bench for ext_mem_stream_feeder: queue-based reference model plus directed pins.
module tb_ext_mem_stream_feeder;

  localparam int IO    = 16;
  localparam int EW    = 32;
  localparam int H     = 1 << 20;
  localparam int AW    = 20;
  localparam int LANES = EW / IO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in, start, out_ready;
  logic [AW-1:0] base_addr, mem_read_addr;
  logic [AW:0]   word_count;
  logic          busy, done, mem_read_en, out_valid;
  logic [EW-1:0] mem_qout;
  logic [IO-1:0] out_data;

  logic [EW-1:0] mem [int];

  ext_mem_stream_feeder #(
    .IO_DATA_WIDTH (IO),
    .EXT_MEM_WIDTH (EW),
    .EXT_MEM_HEIGHT(H)
  ) dut (
    .clk           (clk),
    .rst_in        (rst_in),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .mem_read_addr (mem_read_addr),
    .mem_read_en   (mem_read_en),
    .mem_qout      (mem_qout),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  always @(posedge clk) begin
    if (mem_read_en)
      mem_qout <= mem.exists(int'(mem_read_addr)) ? mem[int'(mem_read_addr)] : 32'hDEAD_BEEF;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected operand stream and read addresses per transfer.
  logic [IO-1:0] exp_q[$];
  int            addr_exp[$];
  bit            busy_m = 0, done_m = 0, stall_prev = 0;
  logic [IO-1:0] prev_data;
  int            issued = 0, popped = 0, xfers = 0;
  int            rx_cnt = 0, rd_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin : monitor
    logic [EW-1:0] w;
    int            a;
    bit            hs, pop_now, busy_n, done_n;
    if (rst_in) begin
      exp_q.delete();
      addr_exp.delete();
      busy_m = 0; done_m = 0; stall_prev = 0;
      issued = 0; popped = 0; xfers = 0;
    end else begin
      chk("busy", busy, busy_m);
      chk("done", done, done_m);
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      hs = out_valid && out_ready;
      pop_now = hs && ((xfers % LANES) == LANES - 1);
      if (out_valid) begin
        chk("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("data", out_data, exp_q[0]);
      end
      if (mem_read_en) begin
        rd_cnt++;
        chk("read_expected", addr_exp.size() > 0, 1);
        if (addr_exp.size() > 0) chk("rd_addr", 64'(mem_read_addr), 64'(addr_exp.pop_front()));
        chk("rd_window", (issued - popped - int'(pop_now)) < 2, 1);
        issued++;
      end
      busy_n = busy_m;
      done_n = 0;
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        xfers++;
        rx_cnt++;
        if (pop_now) popped++;
        if (exp_q.size() == 0 && busy_m) begin
          busy_n = 0;
          done_n = 1;
        end
      end
      if (!busy_m && !done_m && start) begin
        issued = 0; popped = 0; xfers = 0;
        for (int k = 0; k < int'(word_count); k++) begin
          a = (int'(base_addr) + k) % H;
          addr_exp.push_back(a);
          w = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
          for (int l = 0; l < LANES; l++) exp_q.push_back(w[l*IO +: IO]);
        end
        if (word_count == 0) done_n = 1;
        else                 busy_n = 1;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      busy_m = busy_n;
      done_m = done_n;
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n);
    @(posedge clk); #1;
    start = 1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc && done_cnt == d0; i++) begin
      @(negedge clk); #1;
    end
    chk(name, done_cnt != d0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_read_en, 0);
    chk({tag, "_rd_addr"}, 64'(mem_read_addr), 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  int d0, r0, rd0;

  initial begin
    rst_in = 1; start = 0; out_ready = 0; base_addr = '0; word_count = '0;
    mem[32'h10]  = 32'h0002_0001;
    mem[32'h11]  = 32'h0004_0003;
    mem[32'h12]  = 32'h0006_0005;
    mem[32'h20]  = 32'h0008_0007;
    mem[H-1]     = 32'hBBBB_AAAA;
    mem[0]       = 32'hDDDD_CCCC;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_in = 0;

    // Basic stream with hand-computed cycle pins.
    out_ready = 1; r0 = rx_cnt;
    pulse_start(20'h10, 3);
    @(negedge clk);
    chk("basic_t1_rd_en", mem_read_en, 1);
    chk("basic_t1_addr", 64'(mem_read_addr), 64'h10);
    chk("basic_t1_busy", busy, 1);
    @(negedge clk);
    chk("basic_t2_valid", out_valid, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("basic_stream_valid", out_valid, 1);
      chk("basic_stream_data", out_data, 64'(k + 1));
    end
    @(negedge clk);
    chk("basic_done_pulse", done, 1);
    chk("basic_busy_low", busy, 0);
    @(negedge clk);
    chk("basic_done_single", done, 0);
    #1 chk("basic_rx_count", rx_cnt - r0, 6);

    // Backpressure: stalled 5 cycles, then toggling ready.
    out_ready = 0; r0 = rx_cnt; d0 = done_cnt; rd0 = rd_cnt;
    pulse_start(20'h10, 3);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_data", out_data, 16'h0001);
    end
    @(posedge clk); #1 out_ready = 1;
    for (int i = 0; i < 40 && done_cnt == d0; i++) begin
      @(posedge clk); #1 out_ready = ~out_ready;
    end
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_rx_count", rx_cnt - r0, 6);
    chk("bp_reads", rd_cnt - rd0, 3);

    // Empty transfer.
    out_ready = 1; rd0 = rd_cnt; r0 = rx_cnt;
    pulse_start(20'h10, 0);
    @(negedge clk);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_rd_en", mem_read_en, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("empty_no_reads", rd_cnt - rd0, 0);
    chk("empty_no_data", rx_cnt - r0, 0);

    // Address wrap-around at the top of memory.
    rd0 = rd_cnt; r0 = rx_cnt;
    pulse_start(20'hFFFFF, 2);
    @(negedge clk);
    chk("wrap_first_addr", 64'(mem_read_addr), 64'hFFFFF);
    @(negedge clk);
    chk("wrap_second_addr", 64'(mem_read_addr), 64'h0);
    wait_done("wrap_done_seen", 30);
    chk("wrap_rx_count", rx_cnt - r0, 4);
    chk("wrap_reads", rd_cnt - rd0, 2);

    // Reset in the middle of a stream.
    repeat (3) @(posedge clk);
    r0 = rx_cnt;
    pulse_start(20'h10, 3);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rx_before_reset", rx_cnt - r0, 2);
    rst_in = 1; out_ready = 0;
    @(posedge clk); #1 rst_in = 0;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    out_ready = 1; r0 = rx_cnt;
    pulse_start(20'h11, 1);
    wait_done("restart_done_seen", 30);
    chk("restart_rx_count", rx_cnt - r0, 2);

    // start during RUN and during DONE is ignored.
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt; r0 = rx_cnt; rd0 = rd_cnt;
    pulse_start(20'h10, 3);
    repeat (2) @(posedge clk);
    #1 start = 1; base_addr = 20'h20; word_count = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 start = 1;
    @(negedge clk);
    chk("ign_done_cycle", done, 1);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("ign_no_restart_busy", busy, 0);
    repeat (8) @(negedge clk);
    #1;
    chk("ign_done_pulses", done_cnt - d0, 1);
    chk("ign_rx_count", rx_cnt - r0, 6);
    chk("ign_reads", rd_cnt - rd0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
